// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration loader.
//   state_e        : loader FSM states
//   num_words      : words needed to cover the whole chain
//   last_word_bits : valid bits carried by the final word
//   bl_width       : width of the bits_left counter for a given chain length
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SET    = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_CHAIN_LEN  = 1024;
    localparam int DEF_BL_W       = $clog2(DEF_CHAIN_LEN + 1);

    function automatic int num_words(input int chain_len, input int word_width);
        return (chain_len + word_width - 1) / word_width;
    endfunction

    function automatic int last_word_bits(input int chain_len, input int word_width);
        return chain_len - (num_words(chain_len, word_width) - 1) * word_width;
    endfunction

    function automatic int bl_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word-to-bit serializer feeding the configuration chain head.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : take load_data_i / load_bits_i this cycle
//   load_data_i   : word to serialise, bit 0 first
//   load_bits_i   : number of valid bits in load_data_i
//   cfg_shift_o   : current chain bit (holds last value while idle)
//   cfg_cen_o     : high while a valid bit is being presented
//   need_o        : shifter empty or presenting its last bit; a load now
//                   keeps the bit stream gap-free
module cfg_word_serializer
    import fabric_cfg_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CNT_W      = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] load_data_i,
    input  logic [CNT_W-1:0]      load_bits_i,
    output logic                  cfg_shift_o,
    output logic                  cfg_cen_o,
    output logic                  need_o
);

    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign cfg_shift_o = sr_q[0];
    assign cfg_cen_o   = (cnt_q != '0);
    assign need_o      = (cnt_q <= CNT_W'(1));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = load_data_i;
            cnt_d = load_bits_i;
        end else if (cnt_q > CNT_W'(1)) begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
            // Last bit consumed: leave sr_q alone so the chain input keeps
            // its final value through a stall.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fabric_config_loader.sv
// Streams configuration words into the tile shift chain, LSB first, then
// strobes the set line so all tiles latch the new configuration.
//   clk_i, rst_i  : clock, synchronous active-high reset (aborts a load)
//   start_i       : begin a load (only honoured in IDLE)
//   word_valid_i / word_data_i / word_ready_o : config word stream
//   cfg_shift_o   : serial bit to chain head
//   cfg_cen_o     : chain shift enable, one shift per high cycle
//   cfg_set_o     : config latch strobe, SET_CYCLES long
//   busy_o        : accepted start through the done cycle
//   done_o        : one-cycle completion pulse
//   bits_left_o   : chain bits still to shift
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int SET_CYCLES = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           word_valid_i,
    input  logic [WORD_WIDTH-1:0]          word_data_i,
    output logic                           word_ready_o,
    output logic                           cfg_shift_o,
    output logic                           cfg_cen_o,
    output logic                           cfg_set_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [bl_width(CHAIN_LEN)-1:0] bits_left_o
);

    localparam int BL_W      = bl_width(CHAIN_LEN);
    localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_WIDTH);
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_WIDTH);
    localparam int WC_W      = $clog2(NUM_WORDS + 1);
    localparam int CNT_W     = $clog2(WORD_WIDTH + 1);
    localparam int SC_W      = $clog2(SET_CYCLES + 1);

    state_e                state_q;
    logic [WORD_WIDTH-1:0] hold_q;
    logic                  hold_vld_q;
    logic [WC_W-1:0]       words_q;      // words accepted this load
    logic [BL_W-1:0]       bits_left_q;
    logic [SC_W-1:0]       set_cnt_q;
    logic                  cfg_set_q, busy_q, done_q;

    logic                  streaming, accept, ser_need, ser_cen;
    logic                  load_hold, load_direct, ser_load, load_is_last;
    logic [WORD_WIDTH-1:0] ser_data;
    logic [CNT_W-1:0]      ser_bits;

    assign streaming    = (state_q == STREAM);
    assign word_ready_o = streaming && !hold_vld_q && (words_q < WC_W'(NUM_WORDS));
    assign accept       = word_ready_o && word_valid_i;

    // An accepted word bypasses the holding register when the shifter is
    // free next cycle; that gives first-bit latency of one cycle and no
    // bubble between words.
    assign load_hold    = streaming && ser_need && hold_vld_q;
    assign load_direct  = ser_need && accept;
    assign ser_load     = load_hold || load_direct;
    assign ser_data     = hold_vld_q ? hold_q : word_data_i;

    // words_q already counts the held word, but not a word arriving now.
    assign load_is_last = hold_vld_q ? (words_q == WC_W'(NUM_WORDS))
                                     : (words_q == WC_W'(NUM_WORDS - 1));
    assign ser_bits     = load_is_last ? CNT_W'(LAST_BITS) : CNT_W'(WORD_WIDTH);

    cfg_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .CNT_W      (CNT_W)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ser_load),
        .load_data_i (ser_data),
        .load_bits_i (ser_bits),
        .cfg_shift_o (cfg_shift_o),
        .cfg_cen_o   (ser_cen),
        .need_o      (ser_need)
    );

    assign cfg_cen_o   = ser_cen;
    assign cfg_set_o   = cfg_set_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign bits_left_o = bits_left_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            words_q     <= '0;
            bits_left_q <= '0;
            set_cnt_q   <= '0;
            cfg_set_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= STREAM;
                        busy_q      <= 1'b1;
                        bits_left_q <= BL_W'(CHAIN_LEN);
                        words_q     <= '0;
                        hold_vld_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept) words_q <= words_q + WC_W'(1);
                    // ready requires an empty holder, so a refill never
                    // coincides with draining it.
                    if (load_hold) begin
                        hold_vld_q <= 1'b0;
                    end else if (accept && !load_direct) begin
                        hold_q     <= word_data_i;
                        hold_vld_q <= 1'b1;
                    end
                    if (ser_cen) begin
                        bits_left_q <= bits_left_q - BL_W'(1);
                        if (bits_left_q == BL_W'(1)) begin
                            state_q   <= SET;
                            set_cnt_q <= '0;
                            cfg_set_q <= 1'b1;
                        end
                    end
                end
                SET: begin
                    if (set_cnt_q == SC_W'(SET_CYCLES - 1)) begin
                        cfg_set_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        set_cnt_q <= set_cnt_q + SC_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
Upstream feeder for the tile configuration shift chain. Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain head (the first tile's shift_in_from_north / set_in_from_north / cen).
After exactly CHAIN_LEN bits it pulses the set line so every tile latches its new config, then reports done.
A one-word holding buffer allows back-to-back words with no bubble in the shift stream.

Parameters:
WORD_WIDTH, 32, width of incoming config words
CHAIN_LEN, 1024, total bits in the daisy-chained shift register (all tiles)
SET_CYCLES, 1, cycles cfg_set is held high after the last bit (>=1)

Ports:
clk  input  1  fabric clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load; ignored unless idle
word_valid  input  1  word_data is valid
word_data  input  WORD_WIDTH  config word; bit 0 shifted first
word_ready  output  1  loader accepts word this cycle (valid&&ready)
cfg_shift  output  1  serial bit to chain head (shift_in_from_north)
cfg_cen  output  1  chain shift enable; one chain shift per high cycle
cfg_set  output  1  config latch strobe (set_in_from_north)
busy  output  1  high from accepted start through the done cycle
done  output  1  one-cycle pulse when load completes
bits_left  output  clog2(CHAIN_LEN+1)  bits still to shift

Behaviour:
- Reset values: word_ready=0, cfg_shift=0, cfg_cen=0, cfg_set=0, busy=0, done=0, bits_left=0. State=IDLE. Holding and shift registers empty.
- Reset mid-operation aborts immediately. The chain is left partially shifted, and cfg_set must NOT fire.
- NUM_WORDS = ceil(CHAIN_LEN/WORD_WIDTH). The final word contributes CHAIN_LEN - (NUM_WORDS-1)*WORD_WIDTH bits; its upper bits are discarded.
- States: IDLE, STREAM, SET, DONE.
- IDLE:
  - start=1 -> STREAM next cycle, with busy=1 and bits_left=CHAIN_LEN.
  - start while not IDLE is ignored.
- STREAM:
  - word_ready = holding empty AND words_accepted < NUM_WORDS.
  - Accepted word goes to the holding register. It moves to the shift register in the cycle the shift register is empty or emitting its last valid bit.
  - Latency: a word accepted in cycle t drives its bit 0 on cfg_shift with cfg_cen=1 in cycle t+1 when the shifter is empty.
  - Each cfg_cen=1 cycle shifts one bit and decrements bits_left.
  - Shifter empty and holding empty -> cfg_cen=0, and cfg_shift holds its last value (stall, no bit consumed). Underflow stalls indefinitely; no timeout.
  - Words beyond NUM_WORDS are never accepted (word_ready=0).
  - bits_left reaching 0 -> SET. cfg_cen is low in SET.
- SET: cfg_set=1 for exactly SET_CYCLES cycles, cfg_cen=0, then DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE (busy=0).
- cfg_cen and cfg_set are never high in the same cycle. cfg_cen is high for exactly CHAIN_LEN cycles per load.
- Simultaneous start and word_valid in IDLE: the word is not accepted (ready=0 in IDLE); it is taken the next cycle.

Decomposition:
- Shared package fabric_cfg_pkg holds:
  - the state enum (IDLE/STREAM/SET/DONE);
  - a constant function computing NUM_WORDS and the last-word bit count;
  - the bits_left width localparam.
- One sub-module, cfg_word_serializer: the WORD_WIDTH shift register, per-word valid-bit counter, load/last-bit handshake to the holding register.
- The FSM, holding register and global counters stay in the top.

Test Plan:
- WORD_WIDTH=4, CHAIN_LEN=10; start; words 0xA,0x5,0x3 presented continuously -> cfg_shift over cen-high cycles = 0,1,0,1,1,0,1,0,1,1. cfg_cen high 10 consecutive cycles. Upper 2 bits of 0x3 discarded. cfg_set high 1 cycle after the last bit, then done pulse; exactly 3 handshakes.
- Same config, 5-cycle gap before word 2 -> cfg_cen low 5 cycles after bit 3; bits_left holds at 6; bit sequence identical; no extra set.
- word_valid held high after the 3rd word -> word_ready stays 0; 4th word never consumed; busy drops after done.
- start pulsed during STREAM and SET -> ignored: no counter reload, bits_left continues decrementing normally.
- rst asserted after 5 bits shifted -> next cycle all outputs at reset values, cfg_set never high. New start then completes a full 10-bit load correctly.
- SET_CYCLES=3, WORD_WIDTH=32, CHAIN_LEN=64, words 0xFFFFFFFF,0x00000000 -> 32 ones then 32 zeros; cfg_set high exactly 3 cycles; done 1 cycle later.
